wr_circ_buf_engine: RTL and testbench

Write-side engine for per-flow circular buffers in DRAM; it is the counterpart of the read-buffer engine. It accepts a write request (flow, buffer offset, byte count) plus a MAC-width data stream from a local producer. It converts them into NoC0 store messages addressed to the DRAM tile at (DST_DRAM_X, DST_DRAM_Y), splitting a write that wraps past the buffer end into two messages. It reports completion only after every store acknowledgement has returned.

---
 rtl/wr_circ_buf_engine.sv | 206 ++++++++++++++++++++
 tb/tb_wr_circ_buf_engine.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wr_circ_buf_engine.sv
// rtl/wr_circ_buf_engine.sv - write-side circular buffer engine: request + data stream to NoC0 stores
`ifndef NOC_DATA_WIDTH
`define NOC_DATA_WIDTH 512
`endif
`ifndef FLOW_ID_W
`define FLOW_ID_W 8
`endif
`ifndef MSG_DATA_SIZE_WIDTH
`define MSG_DATA_SIZE_WIDTH 16
`endif
`ifndef MAC_INTERFACE_W
`define MAC_INTERFACE_W 512
`endif
`ifndef MAC_PADBYTES_W
`define MAC_PADBYTES_W 6
`endif
`ifndef MSG_TYPE_STORE_MEM
`define MSG_TYPE_STORE_MEM 8'd2
`endif
`ifndef MSG_TYPE_STORE_MEM_ACK
`define MSG_TYPE_STORE_MEM_ACK 8'd3
`endif

// Header layout, MSB first: dst_x[8] dst_y[8] src_x[8] src_y[8] msg_type[8]
// msg_len[8] addr[64] data_size[16], remaining bits zero.
module wr_circ_buf_engine #(
  parameter int BUF_PTR_W  = 12,  // log2 of per-flow buffer bytes, must be >= 7
  parameter int SRC_X      = 0,
  parameter int SRC_Y      = 0,
  parameter int DST_DRAM_X = 0,
  parameter int DST_DRAM_Y = 0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              noc0_wr_buf_val,
  input  logic [`NOC_DATA_WIDTH-1:0]        noc0_wr_buf_data,
  output logic                              wr_buf_noc0_rdy,
  output logic                              wr_buf_noc0_val,
  output logic [`NOC_DATA_WIDTH-1:0]        wr_buf_noc0_data,
  input  logic                              noc0_wr_buf_rdy,
  input  logic                              src_wr_buf_req_val,
  input  logic [`FLOW_ID_W-1:0]             src_wr_buf_req_flowid,
  input  logic [BUF_PTR_W-1:0]              src_wr_buf_req_offset,
  input  logic [`MSG_DATA_SIZE_WIDTH-1:0]   src_wr_buf_req_size,
  output logic                              wr_buf_src_req_rdy,
  input  logic                              src_wr_buf_data_val,
  input  logic [`MAC_INTERFACE_W-1:0]       src_wr_buf_data,
  input  logic                              src_wr_buf_data_last,
  input  logic [`MAC_PADBYTES_W-1:0]        src_wr_buf_data_padbytes,
  output logic                              wr_buf_src_data_rdy,
  output logic                              wr_buf_src_done_val,
  input  logic                              src_wr_buf_done_rdy
);
  localparam int NW = `NOC_DATA_WIDTH;
  localparam int BW = BUF_PTR_W - 5;  // holds up to 2^(BUF_PTR_W-6) beats

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_HDR      = 3'd1;
  localparam logic [2:0] ST_DATA     = 3'd2;
  localparam logic [2:0] ST_WAIT_ACK = 3'd3;
  localparam logic [2:0] ST_DONE     = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [`FLOW_ID_W-1:0] flowid_q, flowid_d;
  logic [BUF_PTR_W-1:0]  offset_q, offset_d;
  logic [BUF_PTR_W:0]    seg0_q, seg0_d;
  logic [BUF_PTR_W:0]    seg1_q, seg1_d;
  logic                  two_segs_q, two_segs_d;
  logic                  seg_idx_q, seg_idx_d;
  logic [BW-1:0]         beats_q, beats_d;
  logic [1:0]            acks_q, acks_d;

  logic [BUF_PTR_W:0]    req_bytes, room_bytes, req_seg0, req_seg1, cur_seg;
  logic [BUF_PTR_W-1:0]  seg_ptr;
  logic [BW-1:0]         msg_len;
  logic [NW-1:0]         hdr_flit;
  logic                  ack_hit;
  logic                  unused_ok;

  // Data-beat control signals and the upper size bits never steer the engine.
  assign unused_ok = ^{src_wr_buf_data_last, src_wr_buf_data_padbytes,
                       noc0_wr_buf_data, src_wr_buf_req_size};

  // Split the request at the buffer end; offset is beat aligned so seg0 is too when it splits.
  always_comb begin
    req_bytes  = src_wr_buf_req_size[BUF_PTR_W:0];
    room_bytes = {1'b1, {BUF_PTR_W{1'b0}}} - {1'b0, src_wr_buf_req_offset};
    req_seg0   = (req_bytes < room_bytes) ? req_bytes : room_bytes;
    req_seg1   = req_bytes - req_seg0;
  end

  // Per-segment header fields; everything derives from latched state so it holds while stalled.
  always_comb begin
    cur_seg = seg_idx_q ? seg1_q : seg0_q;
    seg_ptr = seg_idx_q ? '0 : offset_q;
    msg_len = cur_seg[BUF_PTR_W:6] + BW'(|cur_seg[5:0]);
    hdr_flit = '0;
    hdr_flit[NW-1   -: 8]  = 8'(DST_DRAM_X);
    hdr_flit[NW-9   -: 8]  = 8'(DST_DRAM_Y);
    hdr_flit[NW-17  -: 8]  = 8'(SRC_X);
    hdr_flit[NW-25  -: 8]  = 8'(SRC_Y);
    hdr_flit[NW-33  -: 8]  = `MSG_TYPE_STORE_MEM;
    hdr_flit[NW-41  -: 8]  = 8'(msg_len);
    hdr_flit[NW-49  -: 64] = 64'({flowid_q, seg_ptr});
    hdr_flit[NW-113 -: 16] = 16'(cur_seg);
  end

  // Handshake outputs; the data phase is a direct pass-through of the producer stream.
  always_comb begin
    wr_buf_src_req_rdy  = !rst && (state_q == ST_IDLE);
    wr_buf_src_done_val = !rst && (state_q == ST_DONE);
    wr_buf_noc0_rdy     = !rst && (state_q != ST_IDLE) && (state_q != ST_DONE);
    wr_buf_noc0_val     = !rst && ((state_q == ST_HDR) ||
                                   ((state_q == ST_DATA) && src_wr_buf_data_val));
    wr_buf_src_data_rdy = !rst && (state_q == ST_DATA) && noc0_wr_buf_rdy;
    wr_buf_noc0_data    = (state_q == ST_HDR) ? hdr_flit : src_wr_buf_data;
    ack_hit = wr_buf_noc0_rdy && noc0_wr_buf_val &&
              (noc0_wr_buf_data[NW-33 -: 8] == `MSG_TYPE_STORE_MEM_ACK);
  end

  // Next-state: acks are counted in any busy state so early segment-0 acks are not lost.
  always_comb begin
    state_d    = state_q;
    flowid_d   = flowid_q;
    offset_d   = offset_q;
    seg0_d     = seg0_q;
    seg1_d     = seg1_q;
    two_segs_d = two_segs_q;
    seg_idx_d  = seg_idx_q;
    beats_d    = beats_q;
    acks_d     = acks_q;
    if (ack_hit && (acks_q != 2'd0)) acks_d = acks_q - 2'd1;
    case (state_q)
      ST_IDLE: begin
        if (src_wr_buf_req_val) begin
          flowid_d   = src_wr_buf_req_flowid;
          offset_d   = src_wr_buf_req_offset;
          seg0_d     = req_seg0;
          seg1_d     = req_seg1;
          two_segs_d = (req_seg1 != '0);
          seg_idx_d  = 1'b0;
          if (req_bytes == '0) begin
            // Zero-byte write: no stores, settle one cycle then report completion.
            acks_d  = 2'd0;
            state_d = ST_WAIT_ACK;
          end else begin
            acks_d  = (req_seg1 != '0) ? 2'd2 : 2'd1;
            state_d = ST_HDR;
          end
        end
      end
      ST_HDR: begin
        if (noc0_wr_buf_rdy) begin
          beats_d = msg_len;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (src_wr_buf_data_val && noc0_wr_buf_rdy) begin
          beats_d = beats_q - BW'(1);
          if (beats_q == BW'(1)) begin
            if (!seg_idx_q && two_segs_q) begin
              seg_idx_d = 1'b1;
              state_d   = ST_HDR;
            end else begin
              state_d = ST_WAIT_ACK;
            end
          end
        end
      end
      ST_WAIT_ACK: begin
        if (acks_d == 2'd0) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (src_wr_buf_done_rdy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      flowid_q   <= '0;
      offset_q   <= '0;
      seg0_q     <= '0;
      seg1_q     <= '0;
      two_segs_q <= 1'b0;
      seg_idx_q  <= 1'b0;
      beats_q    <= '0;
      acks_q     <= '0;
    end else begin
      state_q    <= state_d;
      flowid_q   <= flowid_d;
      offset_q   <= offset_d;
      seg0_q     <= seg0_d;
      seg1_q     <= seg1_d;
      two_segs_q <= two_segs_d;
      seg_idx_q  <= seg_idx_d;
      beats_q    <= beats_d;
      acks_q     <= acks_d;
    end
  end

endmodule

// File: tb/tb_wr_circ_buf_engine.sv
// tb/tb_wr_circ_buf_engine.sv - self-checking bench for wr_circ_buf_engine
`timescale 1ns/1ps
module tb_wr_circ_buf_engine;
  localparam int NW = 512, PW = 12, FW = 8, SW = 16, MW = 512, PBW = 6;
  localparam int SX = 1, SY = 2, DX = 5, DY = 6;
  localparam logic [7:0] T_STORE = 8'd2, T_ACK = 8'd3, T_OTHER = 8'd9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst = 1'b1;
  logic           noc0_wr_buf_val = 1'b0;
  logic [NW-1:0]  noc0_wr_buf_data = '0;
  logic           wr_buf_noc0_rdy;
  logic           wr_buf_noc0_val;
  logic [NW-1:0]  wr_buf_noc0_data;
  logic           noc0_wr_buf_rdy = 1'b1;
  logic           src_wr_buf_req_val = 1'b0;
  logic [FW-1:0]  src_wr_buf_req_flowid = '0;
  logic [PW-1:0]  src_wr_buf_req_offset = '0;
  logic [SW-1:0]  src_wr_buf_req_size = '0;
  logic           wr_buf_src_req_rdy;
  logic           src_wr_buf_data_val = 1'b0;
  logic [MW-1:0]  src_wr_buf_data = '0;
  logic           src_wr_buf_data_last = 1'b0;
  logic [PBW-1:0] src_wr_buf_data_padbytes = '0;
  logic           wr_buf_src_data_rdy;
  logic           wr_buf_src_done_val;
  logic           src_wr_buf_done_rdy = 1'b0;

  wr_circ_buf_engine #(.BUF_PTR_W(PW), .SRC_X(SX), .SRC_Y(SY),
                       .DST_DRAM_X(DX), .DST_DRAM_Y(DY)) dut (
    .clk(clk), .rst(rst),
    .noc0_wr_buf_val(noc0_wr_buf_val), .noc0_wr_buf_data(noc0_wr_buf_data),
    .wr_buf_noc0_rdy(wr_buf_noc0_rdy),
    .wr_buf_noc0_val(wr_buf_noc0_val), .wr_buf_noc0_data(wr_buf_noc0_data),
    .noc0_wr_buf_rdy(noc0_wr_buf_rdy),
    .src_wr_buf_req_val(src_wr_buf_req_val), .src_wr_buf_req_flowid(src_wr_buf_req_flowid),
    .src_wr_buf_req_offset(src_wr_buf_req_offset), .src_wr_buf_req_size(src_wr_buf_req_size),
    .wr_buf_src_req_rdy(wr_buf_src_req_rdy),
    .src_wr_buf_data_val(src_wr_buf_data_val), .src_wr_buf_data(src_wr_buf_data),
    .src_wr_buf_data_last(src_wr_buf_data_last), .src_wr_buf_data_padbytes(src_wr_buf_data_padbytes),
    .wr_buf_src_data_rdy(wr_buf_src_data_rdy),
    .wr_buf_src_done_val(wr_buf_src_done_val), .src_wr_buf_done_rdy(src_wr_buf_done_rdy)
  );

  int tests = 0, fails = 0;
  int cyc = 0, n_out = 0, next_tag = 1;
  logic stall_en = 1'b0;

  logic [NW-1:0] exp_q[$];
  logic          exp_hdr[$];
  logic [NW-1:0] hdr_log[$];
  int            flit_cyc[$];
  int            src_tags[$];
  logic          src_lasts[$];
  int            src_pads[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [MW-1:0] beat_data(input int tag);
    logic [31:0] w;
    w = 32'(tag) ^ 32'hA5A5_0000;
    return {16{w}};
  endfunction

  function automatic logic [NW-1:0] mk_hdr(input int flow, input int ptr, input int bytes);
    logic [NW-1:0] h;
    h = '0;
    h[511:504] = 8'(DX);
    h[503:496] = 8'(DY);
    h[495:488] = 8'(SX);
    h[487:480] = 8'(SY);
    h[479:472] = T_STORE;
    h[471:464] = 8'((bytes + 63) / 64);
    h[463:400] = 64'(flow * (1 << PW) + ptr);
    h[399:384] = 16'(bytes);
    return h;
  endfunction

  function automatic logic [NW-1:0] mk_ack(input logic [7:0] typ);
    logic [NW-1:0] a;
    a = '0;
    a[511:504] = 8'(SX);
    a[503:496] = 8'(SY);
    a[495:488] = 8'(DX);
    a[487:480] = 8'(DY);
    a[479:472] = typ;
    return a;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Model: expected outbound flit list for a request, from the buffer-wrap rule.
  task automatic plan(input int flow, input int off, input int size,
                      output int nsegs, output int nbeats);
    int room, s0, s1, tag;
    room = (1 << PW) - off;
    s0 = (size < room) ? size : room;
    s1 = size - s0;
    tag = next_tag;
    nsegs = 0;
    nbeats = 0;
    if (size == 0) return;
    exp_q.push_back(mk_hdr(flow, off, s0)); exp_hdr.push_back(1'b1);
    for (int i = 0; i < (s0 + 63) / 64; i++) begin
      exp_q.push_back(beat_data(tag + nbeats)); exp_hdr.push_back(1'b0); nbeats++;
    end
    nsegs = 1;
    if (s1 > 0) begin
      exp_q.push_back(mk_hdr(flow, 0, s1)); exp_hdr.push_back(1'b1);
      for (int i = 0; i < (s1 + 63) / 64; i++) begin
        exp_q.push_back(beat_data(tag + nbeats)); exp_hdr.push_back(1'b0); nbeats++;
      end
      nsegs = 2;
    end
  endtask

  task automatic feed(input int n, input int pad);
    for (int i = 0; i < n; i++) begin
      src_tags.push_back(next_tag);
      src_lasts.push_back(i == n - 1);
      src_pads.push_back((i == n - 1) ? pad : 0);
      next_tag++;
    end
  endtask

  // Producer: holds valid until accepted, optional random gaps between beats.
  initial begin
    logic fired;
    forever begin
      @(negedge clk);
      fired = src_wr_buf_data_val && wr_buf_src_data_rdy;
      @(posedge clk); #1;
      if (fired) begin
        src_wr_buf_data_val = 1'b0;
        if (src_tags.size() > 0) begin
          void'(src_tags.pop_front()); void'(src_lasts.pop_front()); void'(src_pads.pop_front());
        end
      end
      if (!src_wr_buf_data_val && src_tags.size() > 0 &&
          (!stall_en || $urandom_range(3) != 0)) begin
        src_wr_buf_data_val      = 1'b1;
        src_wr_buf_data          = beat_data(src_tags[0]);
        src_wr_buf_data_last     = src_lasts[0];
        src_wr_buf_data_padbytes = PBW'(src_pads[0]);
      end
    end
  end

  // Outbound NoC backpressure.
  initial begin
    forever begin
      @(posedge clk); #1;
      noc0_wr_buf_rdy = stall_en ? ($urandom_range(2) != 0) : 1'b1;
    end
  end

  // Compare process: every accepted outbound flit against the model, plus hold-while-stalled.
  logic          prev_pend = 1'b0;
  logic [NW-1:0] prev_data = '0;
  always @(negedge clk) begin
    if (rst) begin
      prev_pend = 1'b0;
    end else begin
      if (prev_pend) begin
        tests++;
        if (!wr_buf_noc0_val || wr_buf_noc0_data !== prev_data) begin
          fails++;
          $display("FAIL stall_hold: val=%0b data changed=%0b required val=1 unchanged",
                   wr_buf_noc0_val, wr_buf_noc0_data !== prev_data);
        end
      end
      if (wr_buf_noc0_val && noc0_wr_buf_rdy) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL extra_flit: got %h required none", wr_buf_noc0_data);
        end else begin
          if (wr_buf_noc0_data !== exp_q[0]) begin
            fails++;
            $display("FAIL flit: got %h required %h", wr_buf_noc0_data, exp_q[0]);
          end
          if (exp_hdr[0]) hdr_log.push_back(wr_buf_noc0_data);
          void'(exp_q.pop_front()); void'(exp_hdr.pop_front());
        end
        flit_cyc.push_back(cyc);
        n_out++;
      end
      prev_pend = wr_buf_noc0_val && !noc0_wr_buf_rdy;
      prev_data = wr_buf_noc0_data;
    end
  end

  task automatic issue_req(input int flow, input int off, input int size);
    logic acc;
    @(posedge clk); #1;
    src_wr_buf_req_val    = 1'b1;
    src_wr_buf_req_flowid = FW'(flow);
    src_wr_buf_req_offset = PW'(off);
    src_wr_buf_req_size   = SW'(size);
    acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      if (wr_buf_src_req_rdy) acc = 1'b1;
      @(posedge clk); #1;
    end
    src_wr_buf_req_val = 1'b0;
    chk("req_accepted", 64'(acc), 64'd1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || src_tags.size() != 0) && n < 3000) begin
      @(negedge clk); n++;
    end
    chk("drain_in_time", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic send_flit(input logic [7:0] typ);
    logic acc;
    @(posedge clk); #1;
    noc0_wr_buf_val  = 1'b1;
    noc0_wr_buf_data = mk_ack(typ);
    acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      if (wr_buf_noc0_rdy) acc = 1'b1;
      @(posedge clk); #1;
    end
    noc0_wr_buf_val = 1'b0;
    chk("inbound_accepted", 64'(acc), 64'd1);
  endtask

  task automatic take_done();
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!wr_buf_src_done_val && n < 50);
    chk("done_seen", 64'(wr_buf_src_done_val), 64'd1);
    @(posedge clk); #1;
    src_wr_buf_done_rdy = 1'b1;
    @(negedge clk);
    chk("done_held", 64'(wr_buf_src_done_val), 64'd1);
    @(posedge clk); #1;
    src_wr_buf_done_rdy = 1'b0;
    @(negedge clk);
    chk("idle_after_done_rdy", 64'(wr_buf_src_req_rdy), 64'd1);
    chk("idle_after_done_val", 64'(wr_buf_src_done_val), 64'd0);
  endtask

  // Full transaction: request, data, acks after the stream drains, completion.
  task automatic run_txn(input int flow, input int off, input int size, input int pad);
    int ns, nb;
    plan(flow, off, size, ns, nb);
    feed(nb, pad);
    issue_req(flow, off, size);
    wait_drain();
    @(negedge clk);
    chk("no_done_before_ack", 64'(wr_buf_src_done_val), 64'd0);
    for (int a = 0; a < ns; a++) begin
      send_flit(T_ACK);
      @(negedge clk);
      chk("done_after_ack", 64'(wr_buf_src_done_val), 64'(a == ns - 1));
    end
    take_done();
  endtask

  initial begin
    int ns, nb, base, n;
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_rdy", 64'(wr_buf_src_req_rdy), 64'd0);
    chk("rst_noc_val", 64'(wr_buf_noc0_val), 64'd0);
    chk("rst_done_val", 64'(wr_buf_src_done_val), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_req_rdy", 64'(wr_buf_src_req_rdy), 64'd1);

    // Single segment: flow 3, offset 0, 128 bytes
    hdr_log.delete();
    plan(3, 'h000, 128, ns, nb);
    chk("t1_model_nsegs", 64'(ns), 64'd1);
    feed(nb, 0);
    issue_req(3, 'h000, 128);
    @(negedge clk);
    chk("t1_hdr_next_cycle", 64'(wr_buf_noc0_val), 64'd1);
    wait_drain();
    @(negedge clk);
    chk("t1_no_done_before_ack", 64'(wr_buf_src_done_val), 64'd0);
    send_flit(T_ACK);
    @(negedge clk);
    chk("t1_done_after_ack", 64'(wr_buf_src_done_val), 64'd1);
    take_done();
    chk("t1_hdr_count", 64'(hdr_log.size()), 64'd1);
    chk("t1_addr", hdr_log[0][463:400], 64'h3000);
    chk("t1_size", 64'(hdr_log[0][399:384]), 64'd128);
    chk("t1_len", 64'(hdr_log[0][471:464]), 64'd2);
    chk("t1_type", 64'(hdr_log[0][479:472]), 64'd2);

    // Wrap: offset 0xFC0, 128 bytes, with a non-ack flit dropped while waiting
    hdr_log.delete(); flit_cyc.delete();
    plan(3, 'hFC0, 128, ns, nb);
    chk("t2_model_nsegs", 64'(ns), 64'd2);
    feed(nb, 0);
    issue_req(3, 'hFC0, 128);
    wait_drain();
    chk("t2_flit_count", 64'(flit_cyc.size()), 64'd4);
    chk("t2_back_to_back", 64'(flit_cyc[3] - flit_cyc[0]), 64'd3);
    send_flit(T_ACK);
    @(negedge clk);
    chk("t2_no_done_one_ack", 64'(wr_buf_src_done_val), 64'd0);
    send_flit(T_OTHER);
    @(negedge clk);
    chk("t2_other_type_dropped", 64'(wr_buf_src_done_val), 64'd0);
    send_flit(T_ACK);
    @(negedge clk);
    chk("t2_done_two_acks", 64'(wr_buf_src_done_val), 64'd1);
    take_done();
    chk("t2_addr0", hdr_log[0][463:400], 64'h3FC0);
    chk("t2_size0", 64'(hdr_log[0][399:384]), 64'd64);
    chk("t2_len0", 64'(hdr_log[0][471:464]), 64'd1);
    chk("t2_addr1", hdr_log[1][463:400], 64'h3000);
    chk("t2_size1", 64'(hdr_log[1][399:384]), 64'd64);

    // Partial last beat: 100 bytes at 0x040, padbytes 28 on the final beat
    hdr_log.delete();
    run_txn(5, 'h040, 100, 28);
    chk("t3_addr", hdr_log[0][463:400], 64'h5040);
    chk("t3_size", 64'(hdr_log[0][399:384]), 64'd100);
    chk("t3_len", 64'(hdr_log[0][471:464]), 64'd2);

    // Zero size: completion two cycles after accept, no NoC traffic
    base = n_out;
    issue_req(3, 'h100, 0);
    @(negedge clk);
    chk("t4_no_done_yet", 64'(wr_buf_src_done_val), 64'd0);
    chk("t4_no_flit", 64'(wr_buf_noc0_val), 64'd0);
    @(negedge clk);
    chk("t4_done", 64'(wr_buf_src_done_val), 64'd1);
    take_done();
    chk("t4_flit_total", 64'(n_out - base), 64'd0);

    // Segment-0 ack arrives while segment 1 is still waiting for data
    plan(7, 'hF80, 192, ns, nb);
    feed(2, 0);
    base = n_out;
    issue_req(7, 'hF80, 192);
    n = 0;
    while (n_out - base < 4 && n < 200) begin @(negedge clk); n++; end
    chk("t5_reached_seg1", 64'(n_out - base), 64'd4);
    send_flit(T_ACK);
    @(negedge clk);
    chk("t5_no_done_early", 64'(wr_buf_src_done_val), 64'd0);
    chk("t5_still_in_data", 64'(wr_buf_src_data_rdy), 64'd1);
    feed(1, 0);
    wait_drain();
    @(negedge clk);
    chk("t5_no_done_one_ack", 64'(wr_buf_src_done_val), 64'd0);
    send_flit(T_ACK);
    @(negedge clk);
    chk("t5_done", 64'(wr_buf_src_done_val), 64'd1);
    take_done();

    // Random stalls on both streams
    stall_en = 1'b1;
    run_txn(1, 'h000, 256, 0);
    run_txn(2, 'hF40, 320, 0);
    run_txn(4, 'h800, 64, 10);
    run_txn(6, 'hFC0, 4096, 0);
    run_txn(9, 'hE00, 1000, 24);
    stall_en = 1'b0;

    // Reset mid-transfer, then a clean transaction
    plan(8, 'h000, 256, ns, nb);
    feed(1, 0);
    base = n_out;
    issue_req(8, 'h000, 256);
    n = 0;
    while (n_out - base < 2 && n < 200) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete(); exp_hdr.delete();
    src_tags.delete(); src_lasts.delete(); src_pads.delete();
    @(negedge clk);
    chk("mid_rst_noc_val", 64'(wr_buf_noc0_val), 64'd0);
    chk("mid_rst_req_rdy", 64'(wr_buf_src_req_rdy), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("after_mid_rst_idle", 64'(wr_buf_src_req_rdy), 64'd1);
    run_txn(2, 'h000, 64, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
